// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display fetch owns the single-port RAM during visible
// pixels, host writes are granted in blanking, and a 2-stage pipeline delivers pixels.
module vga_fb_arbiter #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 8,
  parameter int COUNTER_SIZE = 11
) (
  input  logic                  control_clock,
  input  logic                  reset,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic                  frame_start,
  output logic                  wr_overflow
);

  localparam int PIXELS = H_ACTIVE * V_ACTIVE;
  localparam logic [COUNTER_SIZE-1:0] H_ACT  = COUNTER_SIZE'(H_ACTIVE);
  localparam logic [COUNTER_SIZE-1:0] H_LAST = COUNTER_SIZE'(H_TOTAL - 1);
  localparam logic [COUNTER_SIZE-1:0] V_ACT  = COUNTER_SIZE'(V_ACTIVE);
  localparam logic [COUNTER_SIZE-1:0] V_LAST = COUNTER_SIZE'(V_TOTAL - 1);
  localparam logic [ADDR_WIDTH:0]     PIX_LIM   = (ADDR_WIDTH + 1)'(PIXELS);
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);

  logic [COUNTER_SIZE-1:0] h_cnt, v_cnt;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    fetch, line_end, frame_end, in_range, accept;
  logic                    vld_p1, sof_p1;

  assign fetch     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign in_range  = {1'b0, host_wr_addr} < PIX_LIM;

  // Display fetch always wins the RAM; the host only sees ready in blanking.
  assign host_wr_ready = !reset && !fetch;
  assign accept        = host_wr_valid && host_wr_ready;
  assign mem_addr      = fetch ? rd_addr : host_wr_addr;
  assign mem_we        = accept && in_range;
  assign mem_wdata     = host_wr_data;

  // Stage 0: position counters, linear read address, overflow flag
  always_ff @(posedge control_clock) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      rd_addr     <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      // Holds at the last pixel address through vertical blank, so it never overshoots.
      if (frame_end)
        rd_addr <= '0;
      else if (fetch && (rd_addr != LAST_ADDR))
        rd_addr <= rd_addr + 1'b1;
      if (accept && !in_range)
        wr_overflow <= 1'b1;
    end
  end

  // Stage 1: RAM read in flight
  always_ff @(posedge control_clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
    end else begin
      vld_p1 <= fetch;
      sof_p1 <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Stage 2: pixel output, frame_start aligned with the first pixel of the frame
  always_ff @(posedge control_clock) begin
    if (reset) begin
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_data  <= vld_p1 ? mem_rdata : '0;
      pixel_valid <= vld_p1;
      frame_start <= sof_p1;
    end
  end

endmodule
